// File: rtl/link_monitor_pkg.sv
// Shared types and helpers for the link monitor.
`include "link_monitor_defs.vh"

package link_monitor_pkg;

  localparam int LM_STATE_W = `LM_STATE_W;

  typedef enum logic [`LM_STATE_W-1:0] {
    ST_DOWN    = `LM_ST_DOWN,
    ST_QUALIFY = `LM_ST_QUALIFY,
    ST_UP      = `LM_ST_UP,
    ST_HOLDOFF = `LM_ST_HOLDOFF
  } lm_state_e;

  function automatic int lm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/link_monitor_defs.vh
// State codes for the link monitor, shared with the status/register block.
`ifndef LINK_MONITOR_DEFS_VH
`define LINK_MONITOR_DEFS_VH

`define LM_STATE_W   2
`define LM_ST_DOWN    2'd0
`define LM_ST_QUALIFY 2'd1
`define LM_ST_UP      2'd2
`define LM_ST_HOLDOFF 2'd3

`endif

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment yields 1 so the event survives.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/link_monitor.sv
// Link up/down qualification FSM with holdoff after loss and a saturating loss counter.
module link_monitor
  import link_monitor_pkg::*;
#(
  parameter int QUALIFY_CYCLES = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_filter,
  input  logic                  i_clr_cnt,
  output logic                  o_link_up,
  output logic                  o_rise,
  output logic                  o_fall,
  output logic [1:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_loss_cnt
);

  localparam int TMR_W = $clog2(lm_max(QUALIFY_CYCLES, HOLDOFF_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] QUAL_LAST = TMR_W'(QUALIFY_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);

  lm_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             link_up_q, link_up_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             loss_evt;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    loss_evt = 1'b0;
    unique case (state_q)
      ST_DOWN: begin
        if (i_filter) begin
          state_d = ST_QUALIFY;
          timer_d = '0;
        end
      end
      ST_QUALIFY: begin
        if (!i_filter) begin
          state_d = ST_DOWN;
          timer_d = '0;
        end else if (timer_q == QUAL_LAST) begin
          state_d = ST_UP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_UP: begin
        if (!i_filter) begin
          state_d  = ST_HOLDOFF;
          timer_d  = '0;
          loss_evt = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // Input is deliberately ignored here so a flapping link cannot re-qualify early.
        if (timer_q == HOLD_LAST) begin
          state_d = ST_DOWN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_DOWN;
        timer_d = '0;
      end
    endcase

    link_up_d = (state_d == ST_UP);
    rise_d    = (state_d == ST_UP) && (state_q != ST_UP);
    fall_d    = (state_q == ST_UP) && (state_d != ST_UP);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_DOWN;
      timer_q   <= '0;
      link_up_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      link_up_q <= link_up_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_loss_cnt (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .clr     (i_clr_cnt),
    .inc     (loss_evt),
    .cnt     (o_loss_cnt)
  );

  assign o_link_up = link_up_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_link_monitor.sv
// Randomized and directed bench for link_monitor against a run-length based reference model.
module tb_link_monitor;

  localparam int Q    = 4;
  localparam int H    = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          filt = 1'b0;
  logic          clr = 1'b0;
  logic          link_up, rise, fall;
  logic [1:0]    state;
  logic [CW-1:0] loss_cnt;

  int vecs = 0;
  int errs = 0;

  // Reference model: counts consecutive high samples, remaining holdoff edges, and losses.
  int m_run, m_hold, m_cnt;
  bit m_up, m_rise, m_fall;

  always #5 clk = ~clk;

  link_monitor #(
    .QUALIFY_CYCLES(Q),
    .HOLDOFF_CYCLES(H),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clk     (clk),
    .i_arst_n  (arst_n),
    .i_filter  (filt),
    .i_clr_cnt (clr),
    .o_link_up (link_up),
    .o_rise    (rise),
    .o_fall    (fall),
    .o_state   (state),
    .o_loss_cnt(loss_cnt)
  );

  task automatic mdl_reset();
    m_run = 0; m_hold = 0; m_cnt = 0; m_up = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic mdl_edge(input bit f, input bit c);
    bit loss;
    loss = 0; m_rise = 0; m_fall = 0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_up) begin
      if (!f) begin
        m_up = 0; m_hold = H; loss = 1; m_fall = 1;
      end
    end else if (f) begin
      m_run++;
      if (m_run == Q + 1) begin
        m_up = 1; m_rise = 1; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (c) m_cnt = loss ? 1 : 0;
    else if (loss && m_cnt < CMAX) m_cnt++;
  endtask

  function automatic logic [6:0] mdl_vec();
    logic [1:0] st;
    st = (m_hold > 0) ? 2'd3 : m_up ? 2'd2 : (m_run > 0) ? 2'd1 : 2'd0;
    return {st, m_up, m_rise, m_fall, CW'(m_cnt)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {state, link_up, rise, fall, loss_cnt};
  endfunction

  // Drive on the falling edge, advance the model on the rising edge, leave outputs settled.
  task automatic step(input bit f, input bit c);
    @(negedge clk);
    filt = f;
    clr  = c;
    @(posedge clk);
    mdl_edge(f, c);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    filt = 1'b0;
    clr = 1'b0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (dut_vec() !== 7'd0) begin
      errs++;
      $display("FAIL reset_state got=%b want=%b", dut_vec(), 7'd0);
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_qualify();
    for (int i = 0; i <= Q + 1; i++) begin
      step(1'b1, 1'b0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL qualify cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
      vecs++;
      if (i == 0 && state !== 2'd1) begin
        errs++;
        $display("FAIL qualify_entry got=%0d want=1", state);
      end else if (i == Q && {link_up, rise} !== 2'b11) begin
        errs++;
        $display("FAIL qualify_rise got=%b want=11", {link_up, rise});
      end else if (i == Q + 1 && {link_up, rise} !== 2'b10) begin
        errs++;
        $display("FAIL qualify_rise_clear got=%b want=10", {link_up, rise});
      end else if (i < Q && link_up !== 1'b0) begin
        errs++;
        $display("FAIL qualify_early got=%b want=0", link_up);
      end
    end
  endtask

  task automatic test_loss();
    // Assumes UP on entry; drop once, then hold the input high throughout holdoff.
    for (int i = 0; i < H + 1; i++) begin
      step(i != 0, 1'b0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL loss cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
      vecs++;
      if (i == 0 && {fall, state} !== 3'b1_11) begin
        errs++;
        $display("FAIL loss_entry got=%b want=111", {fall, state});
      end else if (i == H && state !== 2'd0) begin
        errs++;
        $display("FAIL holdoff_exit got=%0d want=0", state);
      end
    end
    // Drop the input so the next scenario starts from DOWN with a clean run.
    step(1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) begin
      step(i < 3, 1'b0);
      vecs++;
      if (dut_vec() !== mdl_vec() || link_up !== 1'b0) begin
        errs++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    vecs++;
    if (state !== 2'd0) begin
      errs++;
      $display("FAIL glitch_state got=%0d want=0", state);
    end
  endtask

  task automatic go_up();
    repeat (Q + 1) step(1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [CW-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1'b0, 1'b1);
    vecs++;
    if (loss_cnt !== '0) begin
      errs++;
      $display("FAIL clr_alone got=%0d want=0", loss_cnt);
    end
    for (int n = 0; n < 5; n++) begin
      go_up();
      step(1'b0, 1'b0);
      vecs++;
      if (loss_cnt !== want[n] || dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL saturate n=%0d got=%0d want=%0d", n, loss_cnt, want[n]);
      end
      repeat (H) step(1'b0, 1'b0);
    end
  endtask

  task automatic test_clear_with_loss();
    go_up();
    step(1'b0, 1'b1);
    vecs++;
    if (loss_cnt !== 2'd1 || fall !== 1'b1) begin
      errs++;
      $display("FAIL clr_with_loss got=%0d/%b want=1/1", loss_cnt, fall);
    end
    repeat (H) step(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    go_up();
    step(1'b1, 1'b0);
    @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    mdl_reset();
    vecs++;
    if (dut_vec() !== 7'd0) begin
      errs++;
      $display("FAIL async_reset got=%b want=%b", dut_vec(), 7'd0);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (fall !== 1'b0 || loss_cnt !== '0) begin
      errs++;
      $display("FAIL reset_no_fall got=%b/%0d want=0/0", fall, loss_cnt);
    end
    @(negedge clk);
    filt = 1'b1;
    arst_n = 1'b1;
    @(posedge clk);
    mdl_edge(1'b1, 1'b0);
    #1;
    vecs++;
    if (state !== 2'd1) begin
      errs++;
      $display("FAIL release_first_edge got=%0d want=1", state);
    end
    for (int i = 1; i <= Q; i++) begin
      step(1'b1, 1'b0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL requalify cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    vecs++;
    if ({link_up, rise} !== 2'b11) begin
      errs++;
      $display("FAIL requalify_rise got=%b want=11", {link_up, rise});
    end
  endtask

  task automatic test_random();
    bit f;
    f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) f = ~f;
      step(f, $urandom_range(0, 40) == 0);
      vecs++;
      if (dut_vec() !== mdl_vec()) begin
        errs++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
      vecs++;
      if (rise && fall) begin
        errs++;
        $display("FAIL rise_fall_overlap got=11 want=not both");
      end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_loss();
    test_glitch();
    test_saturation();
    test_clear_with_loss();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
